// File: rtl/bus_arbiter_mux_if.sv
// bus_arbiter_mux_if: master request/address bundle and registered slave-side outputs
interface bus_arbiter_mux_if #(
    parameter int N_MST  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_MST-1:0]        m_req_;
    logic [N_MST*ADDR_W-1:0] m_addr;
    logic [N_MST-1:0]        m_as_;
    logic [N_MST-1:0]        m_rw;
    logic [N_MST*DATA_W-1:0] m_wr_data;
    logic [N_MST-1:0]        m_busy;
    logic [N_MST-1:0]        m_grnt_;
    logic [ADDR_W-1:0]       s_addr;
    logic                    s_as_;
    logic                    s_rw;
    logic [DATA_W-1:0]       s_wr_data;
    logic [1:0]              htrans;
    modport master (
        output m_req_, m_addr, m_as_, m_rw, m_wr_data, m_busy,
        input  m_grnt_, s_addr, s_as_, s_rw, s_wr_data, htrans
    );
    modport slave (
        input  m_req_, m_addr, m_as_, m_rw, m_wr_data, m_busy,
        output m_grnt_, s_addr, s_as_, s_rw, s_wr_data, htrans
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: round-robin bus arbiter with tenure limit and registered slave-side mux
module bus_arbiter_mux #(
    parameter int N_MST    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input logic clk,
    input logic reset_,
    bus_arbiter_mux_if.slave bus
);
    localparam int OW = $clog2(N_MST);
    localparam int CW = MAX_HOLD > 2 ? $clog2(MAX_HOLD) : 1;
    localparam bit ROT = MAX_HOLD != 0;
    localparam logic [CW-1:0] TOP = CW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state, state_nx;
    logic [OW-1:0] own, own_nx, last, rr_idx, p;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N_MST-1:0] req;
    logic others, chg, valid, first, seen, seen_nx, as_sel, busy_sel;
    logic [1:0] htrans_nx;
    assign req = ~bus.m_req_;
    assign others = |(req & ~(N_MST'(1) << own));
    // first requester after the previous owner; the highest offset (the owner itself) ranks last
    always_comb begin
        rr_idx = last;
        p = '0;
        for (int i = N_MST; i >= 1; i--) begin
            p = OW'((int'(last) + i) % N_MST);
            if (req[p]) rr_idx = p;
        end
    end
    always_comb begin
        state_nx = state;
        own_nx = own;
        if (state == IDLE) begin
            if (|req) begin
                state_nx = OWNED;
                own_nx = rr_idx;
            end
        end else if (!bus.m_busy[own]) begin
            if (!req[own]) begin
                state_nx = |req ? OWNED : IDLE;
                own_nx = |req ? rr_idx : own;
            end else if (ROT && cnt == TOP && others) begin
                own_nx = rr_idx;
            end
        end
    end
    assign valid = state_nx == OWNED;
    assign chg = valid && (state == IDLE || own_nx != own);
    assign cnt_nx = (!valid || chg) ? '0 : (ROT && cnt != TOP) ? cnt + 1'b1 : cnt;
    assign as_sel = bus.m_as_[own_nx];
    assign busy_sel = bus.m_busy[own_nx];
    assign first = chg || !seen;
    assign seen_nx = valid && (!as_sel || (!chg && seen));
    assign htrans_nx = !valid ? 2'b00 :
                       !as_sel ? ((first || !busy_sel) ? 2'b10 : 2'b11) :
                       busy_sel ? 2'b01 : 2'b00;
    assign bus.m_grnt_ = state == OWNED ? ~(N_MST'(1) << own) : '1;
    // s_* follow the owner for the coming cycle so a grant change never mixes two masters
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            own <= '0;
            last <= OW'(N_MST - 1);
            cnt <= '0;
            seen <= 1'b0;
            bus.s_addr <= '0;
            bus.s_as_ <= 1'b1;
            bus.s_rw <= 1'b1;
            bus.s_wr_data <= '0;
            bus.htrans <= 2'b00;
        end else begin
            state <= state_nx;
            own <= own_nx;
            if (valid) last <= own_nx;
            cnt <= cnt_nx;
            seen <= seen_nx;
            bus.s_addr <= valid ? bus.m_addr[own_nx*ADDR_W +: ADDR_W] : '0;
            bus.s_as_ <= valid ? as_sel : 1'b1;
            bus.s_rw <= valid ? bus.m_rw[own_nx] : 1'b1;
            bus.s_wr_data <= valid ? bus.m_wr_data[own_nx*DATA_W +: DATA_W] : '0;
            bus.htrans <= htrans_nx;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: directed scoreboard bench for 4-master and 2-master builds
module tb_bus_arbiter_mux;
    logic clk = 1'b0;
    logic reset_ = 1'b1;
    always #5 clk = ~clk;
    bus_arbiter_mux_if #(.N_MST(4), .ADDR_W(32), .DATA_W(32)) b4 ();
    bus_arbiter_mux_if #(.N_MST(2), .ADDR_W(16), .DATA_W(16)) b2 ();
    bus_arbiter_mux #(.N_MST(4), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) u4 (.clk(clk), .reset_(reset_), .bus(b4));
    bus_arbiter_mux #(.N_MST(2), .ADDR_W(16), .DATA_W(16), .MAX_HOLD(4)) u2 (.clk(clk), .reset_(reset_), .bus(b2));
    localparam int G4 = 0, A4 = 1, AS4 = 2, HT4 = 3, RW4 = 4, WD4 = 5, G2 = 6, A2 = 7, AS2 = 8, HT2 = 9;
    typedef struct {
        string tag;
        int sig;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    function automatic logic [31:0] a4(input int i);
        return 32'hA000_0000 + 32'(i) * 32'd16;
    endfunction
    function automatic logic [31:0] d4(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction
    function automatic logic [15:0] a2(input int i);
        return 16'hB000 + 16'(i) * 16'd16;
    endfunction
    function automatic logic [31:0] act(input int s);
        case (s)
            G4: return 32'(b4.m_grnt_);
            A4: return b4.s_addr;
            AS4: return 32'(b4.s_as_);
            HT4: return 32'(b4.htrans);
            RW4: return 32'(b4.s_rw);
            WD4: return b4.s_wr_data;
            G2: return 32'(b2.m_grnt_);
            A2: return 32'(b2.s_addr);
            AS2: return 32'(b2.s_as_);
            HT2: return 32'(b2.htrans);
            default: return 'x;
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic push(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, act(e.sig), e.val);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask
    task automatic idle4();
        b4.m_req_ = '1;
        b4.m_as_ = '1;
        b4.m_rw = '1;
        b4.m_busy = '0;
        for (int i = 0; i < 4; i++) begin
            b4.m_addr[i*32 +: 32] = a4(i);
            b4.m_wr_data[i*32 +: 32] = d4(i);
        end
    endtask
    task automatic idle2();
        b2.m_req_ = '1;
        b2.m_as_ = '1;
        b2.m_rw = '1;
        b2.m_busy = '0;
        for (int i = 0; i < 2; i++) begin
            b2.m_addr[i*16 +: 16] = a2(i);
            b2.m_wr_data[i*16 +: 16] = 16'h5500 + 16'(i);
        end
    endtask
    initial begin
        logic [3:0] g4;
        logic [1:0] g2;
        idle4();
        idle2();
        #1 reset_ = 1'b0;
        #1;
        push("rst grnt", G4, 32'hF);
        push("rst addr", A4, 0);
        push("rst as", AS4, 1);
        push("rst rw", RW4, 1);
        push("rst wd", WD4, 0);
        push("rst htrans", HT4, 0);
        push("rst grnt2", G2, 32'h3);
        drain();
        #1 reset_ = 1'b1;
        // single requester: grant one edge later, first strobe is NONSEQ
        b4.m_req_ = 4'b1110;
        push("034 grnt", G4, 4'b1110);
        push("034 addr", A4, a4(0));
        push("034 ht idle", HT4, 0);
        tick();
        b4.m_as_[0] = 1'b0;
        b4.m_rw[0] = 1'b0;
        push("034 grnt hold", G4, 4'b1110);
        push("034 as", AS4, 0);
        push("034 ht", HT4, 2);
        push("034 rw", RW4, 0);
        push("034 wd", WD4, d4(0));
        tick();
        b4.m_addr[31:0] = 32'h1234_5678;
        push("034 addr2", A4, 32'h1234_5678);
        push("034 ht ns2", HT4, 2);
        tick();
        b4.m_as_[0] = 1'b1;
        b4.m_rw[0] = 1'b1;
        b4.m_addr[31:0] = a4(0);
        push("034 ht end", HT4, 0);
        push("034 as end", AS4, 1);
        tick();
        b4.m_req_ = '1;
        push("rel grnt", G4, 32'hF);
        push("rel as", AS4, 1);
        push("rel addr", A4, 0);
        push("rel rw", RW4, 1);
        tick();
        // direct hand-off from owner 2 to master 0
        b4.m_req_ = 4'b1011;
        push("037 grnt2", G4, 4'b1011);
        push("037 addr2", A4, a4(2));
        tick();
        b4.m_req_ = 4'b1110;
        push("037 grnt0", G4, 4'b1110);
        push("037 addr0", A4, a4(0));
        tick();
        b4.m_req_ = '1;
        push("037 idle", G4, 32'hF);
        tick();
        // busy owner keeps the bus past its tenure limit
        b4.m_req_ = 4'b1101;
        push("036 grnt", G4, 4'b1101);
        push("036 ht0", HT4, 0);
        tick();
        b4.m_req_ = '0;
        b4.m_busy[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b4.m_as_[1] = (i % 3 == 2);
            b4.m_addr[32 +: 32] = 32'h1000_0000 + 32'(i);
            push("036 grnt busy", G4, 4'b1101);
            push("036 htrans", HT4, i == 0 ? 2 : (i % 3 == 2) ? 1 : 3);
            if (i % 3 != 2) push("036 addr", A4, 32'h1000_0000 + 32'(i));
            tick();
        end
        b4.m_busy[1] = 1'b0;
        b4.m_as_[1] = 1'b1;
        b4.m_addr[32 +: 32] = a4(1);
        push("036 rotate", G4, 4'b1011);
        push("036 rot addr", A4, a4(2));
        push("036 rot ht", HT4, 0);
        tick();
        idle4();
        push("036 idle", G4, 32'hF);
        tick();
        // asynchronous reset in the middle of owner 3's burst
        b4.m_req_ = 4'b0111;
        push("038 grnt", G4, 4'b0111);
        tick();
        b4.m_busy[3] = 1'b1;
        b4.m_as_[3] = 1'b0;
        push("038 as", AS4, 0);
        push("038 ht", HT4, 2);
        push("038 grnt hold", G4, 4'b0111);
        tick();
        reset_ = 1'b0;
        #1;
        push("038 rst grnt", G4, 32'hF);
        push("038 rst as", AS4, 1);
        push("038 rst ht", HT4, 0);
        push("038 rst addr", A4, 0);
        drain();
        #1;
        idle4();
        reset_ = 1'b1;
        // all request: tenure-limited rotation starting at master 0
        b4.m_req_ = '0;
        for (int k = 0; k < 17; k++) begin
            g4 = ~(4'b0001 << ((k / 4) % 4));
            push("035 grnt", G4, 32'(g4));
            push("035 addr", A4, a4((k / 4) % 4));
            tick();
        end
        b4.m_req_ = '1;
        push("035 idle", G4, 32'hF);
        tick();
        // two-master build
        reset_ = 1'b0;
        #1;
        push("039 rst grnt", G2, 32'h3);
        drain();
        #1 reset_ = 1'b1;
        b2.m_req_ = '0;
        for (int k = 0; k < 12; k++) begin
            g2 = ~(2'b01 << ((k / 4) % 2));
            push("039 rot grnt", G2, 32'(g2));
            push("039 rot addr", A2, 32'(a2((k / 4) % 2)));
            tick();
        end
        b2.m_req_ = '1;
        push("039 idle", G2, 32'h3);
        tick();
        b2.m_req_ = 2'b10;
        push("039 grnt", G2, 32'h2);
        push("039 addr", A2, 32'(a2(0)));
        tick();
        b2.m_as_[0] = 1'b0;
        push("039 as", AS2, 0);
        push("039 ht", HT2, 2);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
